// File: rtl/sipo_byte_receiver.sv
// Serial-in / parallel-out word receiver with frame alignment, a valid/ready output
// register and sticky overrun / framing error flags.
module sipo_byte_receiver #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             serial_valid,
    input  logic             frame_start,
    input  logic             data_ready,
    input  logic             err_clr,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE_BIT  = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   shreg_r;

    state_t             next_state_s;
    logic [CNT_W-1:0]   next_cnt_s;
    logic [WIDTH-1:0]   shifted_s;
    logic               shreg_load_s;
    logic               word_done_s;
    logic               abandon_s;
    logic               accept_s;
    logic               drop_s;
    logic               consume_s;

    // Bit order is fixed at elaboration; every word is fully overwritten after WIDTH shifts,
    // so stale bits from an abandoned word are pushed out before the word can complete.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] word,
                                                  input logic             bit_in);
        if (MSB_FIRST) begin
            return {word[WIDTH-2:0], bit_in};
        end else begin
            return {bit_in, word[WIDTH-1:1]};
        end
    endfunction

    // Next-state, counter and event decode for the shift FSM.
    always_comb begin
        shifted_s    = shift_in(shreg_r, serial_in);
        next_state_s = state_r;
        next_cnt_s   = cnt_r;
        shreg_load_s = 1'b0;
        word_done_s  = 1'b0;
        abandon_s    = 1'b0;
        if (frame_start) begin
            abandon_s = (state_r == SHIFT);
            if (serial_valid) begin
                shreg_load_s = 1'b1;
                next_cnt_s   = ONE_BIT;
                next_state_s = SHIFT;
            end else begin
                next_cnt_s   = '0;
                next_state_s = IDLE;
            end
        end else if (serial_valid) begin
            shreg_load_s = 1'b1;
            case (state_r)
                IDLE: begin
                    next_cnt_s   = ONE_BIT;
                    next_state_s = SHIFT;
                end
                SHIFT: begin
                    if (cnt_r == LAST_BIT) begin
                        next_cnt_s   = '0;
                        next_state_s = IDLE;
                        word_done_s  = 1'b1;
                    end else begin
                        next_cnt_s   = cnt_r + ONE_BIT;
                        next_state_s = SHIFT;
                    end
                end
                default: begin
                    next_cnt_s   = '0;
                    next_state_s = IDLE;
                end
            endcase
        end else begin
            next_state_s = state_r;
            next_cnt_s   = cnt_r;
        end
    end

    // Output register handshake: a completed word is taken only if the slot is free or
    // being drained on the same edge; otherwise it is dropped and flagged.
    always_comb begin
        consume_s = out_valid && data_ready;
        accept_s  = word_done_s && (!out_valid || data_ready);
        drop_s    = word_done_s && out_valid && !data_ready;
    end

    // FSM state, shift register, output word and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            shreg_r      <= '0;
            parallel_out <= '0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= next_cnt_s;
            busy    <= (next_state_s == SHIFT);
            if (shreg_load_s) begin
                shreg_r <= shifted_s;
            end else begin
                shreg_r <= shreg_r;
            end

            if (accept_s) begin
                parallel_out <= shifted_s;
                out_valid    <= 1'b1;
            end else if (consume_s) begin
                out_valid    <= 1'b0;
            end else begin
                out_valid    <= out_valid;
            end

            // Set events take priority over a simultaneous clear.
            if (drop_s) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end else begin
                overrun <= overrun;
            end

            if (abandon_s) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end else begin
                frame_err <= frame_err;
            end
        end
    end

endmodule

// File: tb/tb_sipo_byte_receiver.sv
// Scoreboard bench: stimulus pushes expected words, negedge monitors pop on each handshake.
module tb_sipo_byte_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic       serial_in, serial_valid, frame_start, data_ready, err_clr;
    logic [7:0] parallel_out;
    logic       out_valid, busy, overrun, frame_err;

    logic       serial_in2, serial_valid2;
    logic [7:0] parallel_out2;
    logic       out_valid2, busy2, overrun2, frame_err2;

    int checks   = 0;
    int failures = 0;
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    always #5 clk = ~clk;

    sipo_byte_receiver #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
        .frame_start(frame_start), .data_ready(data_ready), .err_clr(err_clr),
        .parallel_out(parallel_out), .out_valid(out_valid), .busy(busy),
        .overrun(overrun), .frame_err(frame_err)
    );

    sipo_byte_receiver #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .serial_in(serial_in2), .serial_valid(serial_valid2),
        .frame_start(1'b0), .data_ready(1'b1), .err_clr(1'b0),
        .parallel_out(parallel_out2), .out_valid(out_valid2), .busy(busy2),
        .overrun(overrun2), .frame_err(frame_err2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: one pop per handshake edge seen at the falling edge.
    always @(negedge clk) begin
        if (!reset && out_valid && data_ready) begin
            if (q1.size() == 0) begin
                check("msb_unexpected_word", {24'h0, parallel_out}, 32'hFFFF_FFFF);
            end else begin
                check("msb_word", {24'h0, parallel_out}, {24'h0, q1.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && out_valid2) begin
            if (q2.size() == 0) begin
                check("lsb_unexpected_word", {24'h0, parallel_out2}, 32'hFFFF_FFFF);
            end else begin
                check("lsb_word", {24'h0, parallel_out2}, {24'h0, q2.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic fs);
        serial_in    = b;
        serial_valid = 1'b1;
        frame_start  = fs;
        tick();
        serial_valid = 1'b0;
        frame_start  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i], 1'b0);
    endtask

    initial begin
        logic [7:0] w;
        reset = 1'b1; serial_in = 1'b0; serial_valid = 1'b0; frame_start = 1'b0;
        data_ready = 1'b1; err_clr = 1'b0; serial_in2 = 1'b0; serial_valid2 = 1'b0;
        tick(); tick();
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_parallel_out", {24'h0, parallel_out}, 32'h0);
        check("rst_flags", {30'h0, overrun, frame_err}, 32'h0);
        reset = 1'b0;
        tick();

        // Back-to-back A5 with immediate consumption
        q1.push_back(8'hA5);
        w = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i], 1'b0);
            if (i == 7) check("busy_after_bit1", {31'h0, busy}, 32'h1);
        end
        check("a5_out_valid", {31'h0, out_valid}, 32'h1);
        check("a5_word", {24'h0, parallel_out}, 32'hA5);
        check("a5_busy_done", {31'h0, busy}, 32'h0);
        tick();
        check("a5_valid_clears", {31'h0, out_valid}, 32'h0);

        // A5 with random gaps between bits
        q1.push_back(8'hA5);
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i], 1'b0);
            repeat ($urandom_range(0, 5)) begin
                if (i != 0) check("gap_busy", {31'h0, busy}, 32'h1);
                tick();
            end
            if (i != 0) check("gap_busy_bit", {31'h0, busy}, 32'h1);
        end
        check("gap_busy_done", {31'h0, busy}, 32'h0);
        tick(); tick();

        // Overrun: 3C kept, C3 dropped
        data_ready = 1'b0;
        q1.push_back(8'h3C);
        send_byte(8'h3C);
        send_byte(8'hC3);
        check("ovr_word_kept", {24'h0, parallel_out}, 32'h3C);
        check("ovr_valid", {31'h0, out_valid}, 32'h1);
        check("ovr_flag", {31'h0, overrun}, 32'h1);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        check("ovr_drained", {31'h0, out_valid}, 32'h0);
        check("ovr_sticky", {31'h0, overrun}, 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovr_cleared", {31'h0, overrun}, 32'h0);

        // Set beats clear on the same edge
        q1.push_back(8'h5A);
        send_byte(8'h5A);
        w = 8'h0F;
        for (int i = 7; i >= 1; i--) send_bit(w[i], 1'b0);
        err_clr = 1'b1;
        send_bit(w[0], 1'b0);
        err_clr = 1'b0;
        check("ovr_set_wins", {31'h0, overrun}, 32'h1);
        check("ovr_word_5a", {24'h0, parallel_out}, 32'h5A);
        data_ready = 1'b1;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovr_clear2", {31'h0, overrun}, 32'h0);

        // frame_start in IDLE is not an error
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("fs_idle_no_err", {31'h0, frame_err}, 32'h0);

        // Resync mid-word: 3 junk bits, then 0x81 starting with frame_start
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        q1.push_back(8'h81);
        w = 8'h81;
        send_bit(w[7], 1'b1);
        check("fs_frame_err", {31'h0, frame_err}, 32'h1);
        check("fs_no_emit", {31'h0, out_valid}, 32'h0);
        for (int i = 6; i >= 0; i--) send_bit(w[i], 1'b0);
        check("fs_word_81", {24'h0, parallel_out}, 32'h81);
        check("fs_err_sticky", {31'h0, frame_err}, 32'h1);
        tick();

        // frame_start without data abandons the word and returns to IDLE
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("fs_abort_idle", {31'h0, busy}, 32'h0);
        check("fs_abort_err", {31'h0, frame_err}, 32'h1);

        // Asynchronous reset mid-word
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", {31'h0, busy}, 32'h0);
        check("arst_word", {24'h0, parallel_out}, 32'h0);
        check("arst_flags", {30'h0, overrun, frame_err}, 32'h0);
        #3 reset = 1'b0;
        q1.push_back(8'hFF);
        send_byte(8'hFF);
        check("arst_ff", {24'h0, parallel_out}, 32'hFF);
        check("arst_no_frame_err", {31'h0, frame_err}, 32'h0);
        tick();

        // LSB-first instance
        q2.push_back(8'h05);
        w = 8'b1010_0000;
        for (int i = 7; i >= 0; i--) begin
            serial_in2 = w[i];
            serial_valid2 = 1'b1;
            tick();
        end
        serial_valid2 = 1'b0;
        check("lsb_word_05", {24'h0, parallel_out2}, 32'h05);
        tick(); tick();

        check("q1_drained", q1.size(), 32'h0);
        check("q2_drained", q2.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sipo_byte_receiver.md
SIPO_BYTE_RECEIVER -- requirements
Module: sipo_byte_receiver

Interface
REQ-001 Parameter WIDTH, default 8, sets the word length in bits; legal values are 2 to 32.
REQ-002 Parameter MSB_FIRST, default 1, where 1 means the first received bit lands in bit WIDTH-1 and 0 means it lands in bit 0.
REQ-003 Port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port serial_in, input, 1 bit: serial data, sampled only when serial_valid=1.
REQ-006 Port serial_valid, input, 1 bit: qualifies serial_in for one bit per cycle; gaps of any length are allowed.
REQ-007 Port frame_start, input, 1 bit: word-alignment marker.
REQ-008 Port data_ready, input, 1 bit: downstream accepts parallel_out.
REQ-009 Port err_clr, input, 1 bit: synchronous clear of the sticky error flags.
REQ-010 Port parallel_out, output, WIDTH bits: the assembled word, held stable while out_valid=1.
REQ-011 Port out_valid, output, 1 bit: parallel_out holds an unconsumed word.
REQ-012 Port busy, output, 1 bit: a partial word is in progress.
REQ-013 Port overrun, output, 1 bit: sticky flag, a completed word was dropped.
REQ-014 Port frame_err, output, 1 bit: sticky flag, a partial word was abandoned.

Function
REQ-015 The block SHALL be a two-state FSM with states IDLE (no bits held) and SHIFT (1 to WIDTH-1 bits held); busy=1 exactly in SHIFT.
REQ-016 When serial_valid=1, the bit SHALL be shifted into the shift register (MSB_FIRST=1: shift left, serial_in enters bit 0; MSB_FIRST=0: shift right, serial_in enters bit WIDTH-1), and the bit counter SHALL increment.
REQ-017 Transitions SHALL be: IDLE to SHIFT on a valid bit; SHIFT to IDLE when the WIDTH-th valid bit is sampled, with the counter wrapping to 0; otherwise the state holds.
REQ-018 When serial_valid=0 and frame_start=0, the shift register, counter and state SHALL hold.
REQ-019 Completion: on the edge that samples the WIDTH-th bit, the full word including that bit SHALL be written to parallel_out and out_valid set, so both are visible in the following cycle (latency 0 cycles after the final bit edge).
REQ-020 Handshake: while out_valid=1 and data_ready=1 at an edge, the word SHALL be consumed and out_valid SHALL clear unless a new word completes on the same edge, in which case the new word loads and out_valid stays 1.
REQ-021 Overrun: when a word completes while out_valid=1 and data_ready=0, the new word SHALL be discarded, parallel_out SHALL keep the old word, and overrun SHALL be set.
REQ-022 frame_start=1 with serial_valid=1 SHALL treat serial_in as bit 1 of a new word (counter=1, state SHIFT).
REQ-023 frame_start=1 with serial_valid=0 SHALL clear the counter and enter IDLE.
REQ-024 frame_start=1 while in SHIFT SHALL discard the partial word, never emit it, and set frame_err.
REQ-025 frame_start=1 in IDLE SHALL NOT set frame_err.
REQ-026 err_clr=1 SHALL clear overrun and frame_err at the next edge; a set event on that same edge SHALL win, leaving the flag at 1.
REQ-027 Bits of the shift register not yet written in the current word are don't-care internally but SHALL never appear on parallel_out.

Reset
REQ-028 While reset=1, the block SHALL immediately and asynchronously force state IDLE, counter 0, shift register 0, parallel_out 0, out_valid 0, busy 0, overrun 0 and frame_err 0.
REQ-029 Reset asserted mid-word SHALL discard the partial word without setting frame_err; the first valid bit after release starts a new word.

Verification
REQ-030 Scenario: serial_in 1,0,1,0,0,1,0,1 on 8 consecutive valid cycles with data_ready=1 -> parallel_out=0xA5 and out_valid=1 in the cycle after the 8th bit, clearing one cycle later.
REQ-031 Scenario: same bits with random serial_valid gaps of 0 to 5 cycles -> parallel_out=0xA5; busy=1 from after bit 1 until after bit 8.
REQ-032 Scenario: 0x3C then 0xC3 back-to-back with data_ready held at 0 -> parallel_out stays 0x3C and overrun=1; after data_ready=1 for one cycle, out_valid=0; after err_clr, overrun=0.
REQ-033 Scenario: 3 bits, then frame_start=1 with serial_valid=1, then the 7 remaining bits of 0x81 -> parallel_out=0x81 and frame_err=1.
REQ-034 Scenario: reset pulsed after 5 bits, then 0xFF sent -> parallel_out=0xFF and frame_err=0.
REQ-035 Scenario: MSB_FIRST=0 with bits 1,0,1,0,0,0,0,0 -> parallel_out=0x05.
